// File: rtl/mac_vec_pkg.sv
// Shared types, default widths and arithmetic helpers for the vector MAC core.
// Optional feature: define MAC_SAT_EN to make every add saturate at ACC_W bits
// instead of wrapping in two's complement.
package mac_vec_pkg;

  typedef enum logic {
    MODE_ELEM = 1'b0,
    MODE_ACC  = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int TDATA_W_DEF = 1024;
  localparam int LANES_DEF   = 8;
  localparam int IN_W_DEF    = 8;
  localparam int ACC_W_DEF   = 32;

  // Wide working width for the helpers; any ACC_W up to 62 fits with headroom.
  localparam int ARITH_W = 64;
  typedef logic signed [ARITH_W-1:0] arith_t;

  // Reinterpret the low w bits of p as a signed w-bit product, extended to ARITH_W.
  function automatic arith_t sext_prod(input arith_t p, input int w);
    return (p <<< (ARITH_W - w)) >>> (ARITH_W - w);
  endfunction

  // Add two w-bit signed values at full precision, then clamp or wrap back to w bits.
  function automatic arith_t sat_add(input arith_t x, input arith_t y, input int w);
    arith_t s;
`ifdef MAC_SAT_EN
    arith_t hi;
    arith_t lo;
    s  = x + y;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
`else
    s = x + y;
    return (s <<< (ARITH_W - w)) >>> (ARITH_W - w);
`endif
  endfunction

endpackage

// File: rtl/mac_vec_rtl_lane.sv
// One MAC lane: registered signed product (S1), then add of C or the running
// accumulator into the output register (S2). Saturation follows MAC_SAT_EN
// through sat_add().
module mac_lane
  import mac_vec_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             ld_p1,
  input  logic             ld_p2,
  input  logic             acc_mode,
  input  logic             first_p1,
  input  logic             last_p1,
  input  logic [IN_W-1:0]  a,
  input  logic [IN_W-1:0]  b,
  input  logic [ACC_W-1:0] c,
  output logic [ACC_W-1:0] out_data
);

  logic signed [IN_W-1:0]   a_s;
  logic signed [IN_W-1:0]   b_s;
  logic signed [2*IN_W-1:0] prod_p0;
  logic signed [2*IN_W-1:0] prod_p1;
  logic signed [ACC_W-1:0]  c_p1;
  logic signed [ACC_W-1:0]  acc_p2;
  logic signed [ACC_W-1:0]  out_p2;
  arith_t                   base_p1;
  logic signed [ACC_W-1:0]  sum_p1;

  assign a_s     = $signed(a);
  assign b_s     = $signed(b);
  assign prod_p0 = (2*IN_W)'(a_s) * (2*IN_W)'(b_s);

  // Stage 0 -> 1: capture the product and C operand of a joined beat
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      prod_p1 <= '0;
      c_p1    <= '0;
    end else if (ld_p1) begin
      prod_p1 <= prod_p0;
      c_p1    <= $signed(c);
    end
  end

  // First beat of a packet (or any ELEM beat) adds C; later ACC beats add the accumulator
  always_comb begin
    base_p1 = (!acc_mode || first_p1) ? arith_t'(c_p1) : arith_t'(acc_p2);
    sum_p1  = ACC_W'(sat_add(base_p1, sext_prod(arith_t'($unsigned(prod_p1)), 2*IN_W), ACC_W));
  end

  // Stage 1 -> 2: update the output register and/or the accumulator
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_p2 <= '0;
      out_p2 <= '0;
    end else if (ld_p2) begin
      if (!acc_mode || last_p1) out_p2 <= sum_p1;
      if (acc_mode) acc_p2 <= last_p1 ? '0 : sum_p1;
    end
  end

  assign out_data = out_p2;

endmodule

// File: rtl/mac_vec_rtl.sv
// Multi-lane AXI4-Stream MAC core under ap_ctrl_hs handshake.
// ELEM mode: out = a*b + c per beat. ACC mode: one reduced beat per packet.
// Holds the control FSM, the three-stream join, stage valids and tlast/err logic;
// the arithmetic lives in mac_lane. Define MAC_SAT_EN for saturating adds.
module mac_vec_rtl
  import mac_vec_pkg::*;
#(
  parameter int TDATA_W = TDATA_W_DEF,
  parameter int LANES   = LANES_DEF,
  parameter int IN_W    = IN_W_DEF,
  parameter int ACC_W   = ACC_W_DEF
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 ap_start,
  output logic                 ap_idle,
  output logic                 ap_done,
  output logic                 ap_ready,
  input  logic                 mode,
  output logic                 err_last,
  input  logic                 s_axis_a_tvalid,
  input  logic [TDATA_W-1:0]   s_axis_a_tdata,
  input  logic [TDATA_W/8-1:0] s_axis_a_tkeep,
  input  logic                 s_axis_a_tlast,
  output logic                 s_axis_a_tready,
  input  logic                 s_axis_b_tvalid,
  input  logic [TDATA_W-1:0]   s_axis_b_tdata,
  input  logic [TDATA_W/8-1:0] s_axis_b_tkeep,
  input  logic                 s_axis_b_tlast,
  output logic                 s_axis_b_tready,
  input  logic                 s_axis_c_tvalid,
  input  logic [TDATA_W-1:0]   s_axis_c_tdata,
  input  logic [TDATA_W/8-1:0] s_axis_c_tkeep,
  input  logic                 s_axis_c_tlast,
  output logic                 s_axis_c_tready,
  output logic                 m_axis_out_tvalid,
  output logic [TDATA_W-1:0]   m_axis_out_tdata,
  output logic [TDATA_W/8-1:0] m_axis_out_tkeep,
  output logic                 m_axis_out_tlast,
  input  logic                 m_axis_out_tready
);

  localparam int KEEP_B = LANES * ACC_W / 8;

  state_e state_q, state_d;
  mode_e  mode_q;
  logic   start_fire;
  logic   join_p0;
  logic   first_p0;
  logic   pkt_end_q;
  logic   err_q;
  logic   vld_p1, last_p1, first_p1;
  logic   vld_p2, tlast_p2;
  logic   en_out, s1_en, out_fire;
  logic   unused_in;
  logic [ACC_W-1:0] lane_out [LANES];

  // Input tkeep is ignored and only part of each tdata is read.
  assign unused_in = ^{s_axis_a_tkeep, s_axis_b_tkeep, s_axis_c_tkeep,
                       s_axis_a_tdata, s_axis_b_tdata, s_axis_c_tdata};

  assign start_fire = (state_q == IDLE) && ap_start;
  assign en_out     = !vld_p2 || m_axis_out_tready;
  assign s1_en      = !vld_p1 || en_out;
  assign out_fire   = vld_p2 && m_axis_out_tready;
  // Once the packet's last beat is joined, nothing more is taken until the next start.
  assign join_p0    = (state_q == BUSY) && !pkt_end_q && s1_en &&
                      s_axis_a_tvalid && s_axis_b_tvalid && s_axis_c_tvalid;

  assign s_axis_a_tready = join_p0;
  assign s_axis_b_tready = join_p0;
  assign s_axis_c_tready = join_p0;

  // FSM state register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // FSM next-state: run from start until the tlast output beat is accepted
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ap_start) state_d = BUSY;
      BUSY:    if (out_fire && tlast_p2) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: ap_ctrl_hs status
  always_comb begin
    ap_idle  = (state_q == IDLE);
    ap_done  = (state_q == DONE);
    ap_ready = (state_q == DONE);
  end

  // Per-packet control: mode capture, first-beat tracking, end-of-packet and sticky tlast error
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      mode_q    <= MODE_ELEM;
      first_p0  <= 1'b0;
      pkt_end_q <= 1'b0;
      err_q     <= 1'b0;
    end else if (start_fire) begin
      mode_q    <= mode_e'(mode);
      first_p0  <= 1'b1;
      pkt_end_q <= 1'b0;
      err_q     <= 1'b0;
    end else if (join_p0) begin
      first_p0  <= 1'b0;
      if (s_axis_a_tlast) pkt_end_q <= 1'b1;
      if ((s_axis_a_tlast != s_axis_b_tlast) || (s_axis_a_tlast != s_axis_c_tlast))
        err_q <= 1'b1;
    end
  end

  assign err_last = err_q;

  // Stage 0 -> 1: valid and sideband for the product stage
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
      first_p1 <= 1'b0;
    end else begin
      if (s1_en) vld_p1 <= join_p0;
      if (join_p0) begin
        last_p1  <= s_axis_a_tlast;
        first_p1 <= first_p0;
      end
    end
  end

  // Stage 1 -> 2: output valid; ACC mode emits only on the packet's last beat
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld_p2   <= 1'b0;
      tlast_p2 <= 1'b0;
    end else if (en_out) begin
      vld_p2 <= vld_p1 && ((mode_q == MODE_ELEM) || last_p1);
      if (vld_p1) tlast_p2 <= last_p1;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mac_lane #(
      .IN_W  (IN_W),
      .ACC_W (ACC_W)
    ) u_lane (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .ld_p1    (join_p0),
      .ld_p2    (en_out && vld_p1),
      .acc_mode (mode_q == MODE_ACC),
      .first_p1 (first_p1),
      .last_p1  (last_p1),
      .a        (s_axis_a_tdata[i*IN_W +: IN_W]),
      .b        (s_axis_b_tdata[i*IN_W +: IN_W]),
      .c        (s_axis_c_tdata[i*ACC_W +: ACC_W]),
      .out_data (lane_out[i])
    );
  end

  // Pack lane results low, zero above, with tkeep covering only the lane bytes
  always_comb begin
    m_axis_out_tdata = '0;
    m_axis_out_tkeep = '0;
    for (int i = 0; i < LANES; i++) m_axis_out_tdata[i*ACC_W +: ACC_W] = lane_out[i];
    for (int j = 0; j < KEEP_B; j++) m_axis_out_tkeep[j] = 1'b1;
  end

  assign m_axis_out_tvalid = vld_p2;
  assign m_axis_out_tlast  = tlast_p2;

endmodule

// File: tb/tb_mac_vec_rtl.sv
// Directed self-checking bench for mac_vec_rtl (4 lanes, 8-bit operands, 16-bit accumulator).
module tb_mac_vec_rtl;

  localparam int TDATA_W = 128;
  localparam int LANES   = 4;
  localparam int IN_W    = 8;
  localparam int ACC_W   = 16;
  localparam int KW      = TDATA_W / 8;

  logic ap_clk = 1'b0;
  logic ap_rst_n, ap_start, ap_idle, ap_done, ap_ready, mode, err_last;
  logic s_axis_a_tvalid, s_axis_a_tlast, s_axis_a_tready;
  logic s_axis_b_tvalid, s_axis_b_tlast, s_axis_b_tready;
  logic s_axis_c_tvalid, s_axis_c_tlast, s_axis_c_tready;
  logic [TDATA_W-1:0] s_axis_a_tdata, s_axis_b_tdata, s_axis_c_tdata;
  logic [KW-1:0]      s_axis_a_tkeep, s_axis_b_tkeep, s_axis_c_tkeep;
  logic m_axis_out_tvalid, m_axis_out_tlast, m_axis_out_tready;
  logic [TDATA_W-1:0] m_axis_out_tdata;
  logic [KW-1:0]      m_axis_out_tkeep;

  always #5 ap_clk = ~ap_clk;

  mac_vec_rtl #(.TDATA_W(TDATA_W), .LANES(LANES), .IN_W(IN_W), .ACC_W(ACC_W)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_idle(ap_idle),
    .ap_done(ap_done), .ap_ready(ap_ready), .mode(mode), .err_last(err_last),
    .s_axis_a_tvalid(s_axis_a_tvalid), .s_axis_a_tdata(s_axis_a_tdata),
    .s_axis_a_tkeep(s_axis_a_tkeep), .s_axis_a_tlast(s_axis_a_tlast), .s_axis_a_tready(s_axis_a_tready),
    .s_axis_b_tvalid(s_axis_b_tvalid), .s_axis_b_tdata(s_axis_b_tdata),
    .s_axis_b_tkeep(s_axis_b_tkeep), .s_axis_b_tlast(s_axis_b_tlast), .s_axis_b_tready(s_axis_b_tready),
    .s_axis_c_tvalid(s_axis_c_tvalid), .s_axis_c_tdata(s_axis_c_tdata),
    .s_axis_c_tkeep(s_axis_c_tkeep), .s_axis_c_tlast(s_axis_c_tlast), .s_axis_c_tready(s_axis_c_tready),
    .m_axis_out_tvalid(m_axis_out_tvalid), .m_axis_out_tdata(m_axis_out_tdata),
    .m_axis_out_tkeep(m_axis_out_tkeep), .m_axis_out_tlast(m_axis_out_tlast),
    .m_axis_out_tready(m_axis_out_tready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Beat tables filled by each test
  logic [TDATA_W-1:0] beat_a [8];
  logic [TDATA_W-1:0] beat_b [8];
  logic [TDATA_W-1:0] beat_c [8];
  logic               last_a [8];
  logic               last_b [8];
  logic               last_c [8];

  // Observations collected by run_pkt
  logic [TDATA_W-1:0] od [$];
  logic               ol [$];
  logic [KW-1:0]      okp [$];
  int                 oc [$];
  int                 jc [$];
  int done_cyc, done_cnt, early_cnt, stable_viol, stall_rdy, rdy_split;

  function automatic logic [TDATA_W-1:0] pk_ab(input int v0, input int v1, input int v2, input int v3);
    logic [TDATA_W-1:0] r;
    int v [4];
    v = '{v0, v1, v2, v3};
    r = '0;
    for (int i = 0; i < LANES; i++) r[i*IN_W +: IN_W] = v[i][IN_W-1:0];
    return r;
  endfunction

  function automatic logic [TDATA_W-1:0] pk_c(input int v0, input int v1, input int v2, input int v3);
    logic [TDATA_W-1:0] r;
    int v [4];
    v = '{v0, v1, v2, v3};
    r = '0;
    for (int i = 0; i < LANES; i++) r[i*ACC_W +: ACC_W] = v[i][ACC_W-1:0];
    return r;
  endfunction

  task automatic set_beat(input int k, input int a, input int b, input int c,
                          input logic la, input logic lb, input logic lc);
    beat_a[k] = pk_ab(a, a, a, a);
    beat_b[k] = pk_ab(b, b, b, b);
    beat_c[k] = pk_c(c, c, c, c);
    last_a[k] = la;
    last_b[k] = lb;
    last_c[k] = lc;
  endtask

  task automatic idle_inputs();
    s_axis_a_tvalid = 0; s_axis_b_tvalid = 0; s_axis_c_tvalid = 0;
    s_axis_a_tlast = 0; s_axis_b_tlast = 0; s_axis_c_tlast = 0;
    m_axis_out_tready = 1;
  endtask

  // Start a packet, feed nb beats and record every handshake until ap_done (bounded).
  task automatic run_pkt(input logic m, input int nb, input int b_delay,
                         input int st_at, input int st_len);
    int bi, wait_c;
    logic prev_hold, prev_l;
    logic [TDATA_W-1:0] prev_d;
    od.delete(); ol.delete(); okp.delete(); oc.delete(); jc.delete();
    done_cyc = -1; done_cnt = 0; early_cnt = 0; stable_viol = 0; stall_rdy = 0; rdy_split = 0;
    bi = 0; wait_c = 0; prev_hold = 0; prev_l = 0; prev_d = '0;
    @(negedge ap_clk);
    mode = m;
    ap_start = 1;
    for (int t = 0; t < 200; t++) begin
      @(negedge ap_clk);
      ap_start = 0;
      if (bi < nb) begin
        s_axis_a_tvalid = 1;
        s_axis_c_tvalid = 1;
        s_axis_b_tvalid = (wait_c >= b_delay);
        s_axis_a_tdata = beat_a[bi]; s_axis_b_tdata = beat_b[bi]; s_axis_c_tdata = beat_c[bi];
        s_axis_a_tlast = last_a[bi]; s_axis_b_tlast = last_b[bi]; s_axis_c_tlast = last_c[bi];
      end else begin
        s_axis_a_tvalid = 0; s_axis_b_tvalid = 0; s_axis_c_tvalid = 0;
      end
      m_axis_out_tready = !(t >= st_at && t < st_at + st_len);
      #1;
      if (s_axis_a_tready !== s_axis_b_tready || s_axis_a_tready !== s_axis_c_tready) rdy_split++;
      if (s_axis_a_tready === 1'b1) begin
        if (!(s_axis_a_tvalid && s_axis_b_tvalid && s_axis_c_tvalid)) early_cnt++;
        jc.push_back(t);
        bi++;
        wait_c = 0;
      end else if (bi < nb) begin
        wait_c++;
      end
      if (prev_hold && (m_axis_out_tvalid !== 1'b1 || m_axis_out_tdata !== prev_d ||
                        m_axis_out_tlast !== prev_l)) stable_viol++;
      if (!m_axis_out_tready && s_axis_a_tready === 1'b1) stall_rdy++;
      if (m_axis_out_tvalid === 1'b1 && m_axis_out_tready) begin
        od.push_back(m_axis_out_tdata);
        ol.push_back(m_axis_out_tlast);
        okp.push_back(m_axis_out_tkeep);
        oc.push_back(t);
      end
      prev_hold = (m_axis_out_tvalid === 1'b1) && !m_axis_out_tready;
      prev_d = m_axis_out_tdata;
      prev_l = m_axis_out_tlast;
      if (ap_done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = t;
      end
      if (done_cyc >= 0 && t >= done_cyc + 2) break;
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    ap_rst_n = 0; ap_start = 0; mode = 0;
    idle_inputs();
    s_axis_a_tdata = '0; s_axis_b_tdata = '0; s_axis_c_tdata = '0;
    s_axis_a_tkeep = '1; s_axis_b_tkeep = '1; s_axis_c_tkeep = '1;
    repeat (3) @(negedge ap_clk);
    ap_rst_n = 1;
    s_axis_a_tvalid = 1; s_axis_b_tvalid = 1; s_axis_c_tvalid = 1;
    @(negedge ap_clk); #1;
    n_checks++;
    if (ap_idle !== 1'b1 || ap_done !== 1'b0 || ap_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: idle/done/ready=%b%b%b want 100", ap_idle, ap_done, ap_ready);
    end
    n_checks++;
    if ({s_axis_a_tready, s_axis_b_tready, s_axis_c_tready} !== 3'b000) begin
      n_fail++; $display("FAIL reset_tready: got %b%b%b want 000 while idle",
                         s_axis_a_tready, s_axis_b_tready, s_axis_c_tready);
    end
    n_checks++;
    if (m_axis_out_tvalid !== 1'b0 || m_axis_out_tdata !== '0 || err_last !== 1'b0) begin
      n_fail++; $display("FAIL reset_out: tvalid=%b tdata=%h err=%b want 0/0/0",
                         m_axis_out_tvalid, m_axis_out_tdata, err_last);
    end
    idle_inputs();
  endtask

  task automatic test_elem();
    for (int k = 0; k < 3; k++) set_beat(k, 3, -4, 100, k == 2, k == 2, k == 2);
    run_pkt(1'b0, 3, 0, 999, 0);
    n_checks++;
    if (od.size() != 3) begin n_fail++; $display("FAIL elem_count: got %0d beats want 3", od.size()); end
    for (int k = 0; k < od.size() && k < 3; k++) begin
      n_checks++;
      if (od[k] !== pk_c(88, 88, 88, 88) || ol[k] !== (k == 2)) begin
        n_fail++; $display("FAIL elem_beat%0d: got %h last=%b want lanes 88 last=%b", k, od[k], ol[k], k == 2);
      end
    end
    if (od.size() == 3) begin
      n_checks++;
      if (okp[0] !== 16'h00FF) begin n_fail++; $display("FAIL elem_tkeep: got %h want 00ff", okp[0]); end
      n_checks++;
      if (oc[0] != jc[0] + 2) begin n_fail++; $display("FAIL elem_latency: out at %0d want %0d", oc[0], jc[0] + 2); end
      n_checks++;
      if (done_cyc != oc[2] + 1 || done_cnt != 1) begin
        n_fail++; $display("FAIL elem_done: at %0d count %0d want at %0d count 1", done_cyc, done_cnt, oc[2] + 1);
      end
    end
    n_checks++;
    if (ap_idle !== 1'b1) begin n_fail++; $display("FAIL elem_idle: got %b want 1", ap_idle); end
  endtask

  task automatic test_acc();
    set_beat(0, 2, 5, 10, 0, 0, 0);
    for (int k = 1; k < 4; k++) set_beat(k, 2, 5, 999, k == 3, k == 3, k == 3);
    run_pkt(1'b1, 4, 0, 999, 0);
    n_checks++;
    if (od.size() != 1) begin n_fail++; $display("FAIL acc_count: got %0d beats want 1", od.size()); end
    else begin
      n_checks++;
      if (od[0] !== pk_c(50, 50, 50, 50) || ol[0] !== 1'b1) begin
        n_fail++; $display("FAIL acc_value: got %h last=%b want lanes 50 last=1", od[0], ol[0]);
      end
    end
    n_checks++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL acc_done: got %0d pulses want 1", done_cnt); end
  endtask

  task automatic test_lanes();
    beat_a[0] = pk_ab(1, 2, 3, 4);
    beat_b[0] = pk_ab(5, -6, 7, -8);
    beat_c[0] = pk_c(10, 20, 30, 40);
    last_a[0] = 1; last_b[0] = 1; last_c[0] = 1;
    run_pkt(1'b0, 1, 0, 999, 0);
    n_checks++;
    if (od.size() != 1 || od[0] !== pk_c(15, 8, 51, 8)) begin
      n_fail++; $display("FAIL lanes_value: got %0d beats first %h want %h", od.size(),
                         (od.size() > 0) ? od[0] : '0, pk_c(15, 8, 51, 8));
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) set_beat(k, k + 1, 2, k, k == 3, k == 3, k == 3);
    run_pkt(1'b0, 4, 0, 999, 0);
    n_checks++;
    if (od.size() != 4) begin n_fail++; $display("FAIL b2b_count: got %0d beats want 4", od.size()); end
    else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (od[k] !== pk_c(3*k + 2, 3*k + 2, 3*k + 2, 3*k + 2)) begin
          n_fail++; $display("FAIL b2b_beat%0d: got %h want lanes %0d", k, od[k], 3*k + 2);
        end
      end
      n_checks++;
      if (jc[3] - jc[0] != 3 || oc[3] - oc[0] != 3) begin
        n_fail++; $display("FAIL b2b_throughput: join span %0d out span %0d want 3/3", jc[3] - jc[0], oc[3] - oc[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 6; k++) set_beat(k, k + 1, 2, k, k == 5, k == 5, k == 5);
    run_pkt(1'b0, 6, 0, 3, 5);
    n_checks++;
    if (od.size() != 6) begin n_fail++; $display("FAIL bp_count: got %0d beats want 6", od.size()); end
    for (int k = 0; k < od.size() && k < 6; k++) begin
      n_checks++;
      if (od[k] !== pk_c(3*k + 2, 3*k + 2, 3*k + 2, 3*k + 2) || ol[k] !== (k == 5)) begin
        n_fail++; $display("FAIL bp_beat%0d: got %h last=%b want lanes %0d", k, od[k], ol[k], 3*k + 2);
      end
    end
    n_checks++;
    if (stable_viol != 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes while stalled want 0", stable_viol); end
    n_checks++;
    if (stall_rdy != 0) begin n_fail++; $display("FAIL bp_tready: got %0d joins while stalled want 0", stall_rdy); end
  endtask

  task automatic test_stagger();
    set_beat(0, -2, -3, -10, 1, 1, 1);
    run_pkt(1'b0, 1, 3, 999, 0);
    n_checks++;
    if (early_cnt != 0 || rdy_split != 0) begin
      n_fail++; $display("FAIL stagger_join: early=%0d split=%0d want 0/0", early_cnt, rdy_split);
    end
    n_checks++;
    if (jc.size() != 1 || jc[0] != 3) begin
      n_fail++; $display("FAIL stagger_cycle: got %0d joins first at %0d want 1 at 3", jc.size(), (jc.size() > 0) ? jc[0] : -1);
    end
    n_checks++;
    if (od.size() != 1 || od[0] !== pk_c(-4, -4, -4, -4)) begin
      n_fail++; $display("FAIL stagger_value: got %0d beats want lanes -4", od.size());
    end
  endtask

  task automatic test_overflow();
    int exp_hi, exp_lo;
`ifdef MAC_SAT_EN
    exp_hi = 32767;  exp_lo = -32768;
`else
    exp_hi = -16640; exp_lo = 16512;
`endif
    set_beat(0, 127, 127, 32767, 0, 0, 0);
    set_beat(1, -128, 127, -32768, 1, 1, 1);
    run_pkt(1'b0, 2, 0, 999, 0);
    n_checks++;
    if (od.size() != 2) begin n_fail++; $display("FAIL ovf_count: got %0d beats want 2", od.size()); end
    else begin
      n_checks++;
      if (od[0] !== pk_c(exp_hi, exp_hi, exp_hi, exp_hi)) begin
        n_fail++; $display("FAIL ovf_pos: got %h want lanes %0d", od[0], exp_hi);
      end
      n_checks++;
      if (od[1] !== pk_c(exp_lo, exp_lo, exp_lo, exp_lo)) begin
        n_fail++; $display("FAIL ovf_neg: got %h want lanes %0d", od[1], exp_lo);
      end
    end
  endtask

  task automatic test_err();
    set_beat(0, 1, 1, 0, 1, 0, 1);
    run_pkt(1'b0, 1, 0, 999, 0);
    n_checks++;
    if (od.size() != 1 || ol[0] !== 1'b1 || done_cnt != 1) begin
      n_fail++; $display("FAIL err_pkt: got %0d beats, %0d done pulses want 1 beat tlast, 1 pulse", od.size(), done_cnt);
    end
    repeat (3) @(negedge ap_clk);
    #1;
    n_checks++;
    if (err_last !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err_last); end
    set_beat(0, 1, 1, 0, 1, 1, 1);
    run_pkt(1'b0, 1, 0, 999, 0);
    n_checks++;
    if (err_last !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b want 0 after restart", err_last); end
  endtask

  task automatic test_reset_mid();
    int dn;
    dn = 0;
    @(negedge ap_clk);
    mode = 1; ap_start = 1;
    @(negedge ap_clk);
    ap_start = 0;
    s_axis_a_tvalid = 1; s_axis_b_tvalid = 1; s_axis_c_tvalid = 1;
    s_axis_a_tdata = pk_ab(1, 1, 1, 1); s_axis_b_tdata = pk_ab(1, 1, 1, 1); s_axis_c_tdata = pk_c(5, 5, 5, 5);
    s_axis_a_tlast = 0; s_axis_b_tlast = 1; s_axis_c_tlast = 0;
    @(negedge ap_clk);
    s_axis_b_tlast = 0;
    #1;
    n_checks++;
    if (err_last !== 1'b1 || ap_idle !== 1'b0) begin
      n_fail++; $display("FAIL mid_pre: err=%b idle=%b want 1/0", err_last, ap_idle);
    end
    #1 ap_rst_n = 0;
    #1;
    n_checks++;
    if (ap_idle !== 1'b1 || err_last !== 1'b0 || s_axis_a_tready !== 1'b0 ||
        m_axis_out_tvalid !== 1'b0 || m_axis_out_tdata !== '0 || m_axis_out_tkeep !== 16'h00FF) begin
      n_fail++; $display("FAIL mid_reset: idle=%b err=%b rdy=%b tvalid=%b tdata=%h want 1/0/0/0/0",
                         ap_idle, err_last, s_axis_a_tready, m_axis_out_tvalid, m_axis_out_tdata);
    end
    repeat (2) begin @(negedge ap_clk); if (ap_done === 1'b1) dn++; end
    ap_rst_n = 1;
    idle_inputs();
    repeat (3) begin @(negedge ap_clk); #1; if (ap_done === 1'b1) dn++; end
    n_checks++;
    if (dn != 0) begin n_fail++; $display("FAIL mid_nodone: got %0d done pulses want 0", dn); end
    set_beat(0, 3, 4, 5, 1, 1, 1);
    run_pkt(1'b1, 1, 0, 999, 0);
    n_checks++;
    if (od.size() != 1 || od[0] !== pk_c(17, 17, 17, 17) || done_cnt != 1) begin
      n_fail++; $display("FAIL mid_recover: got %0d beats, %0d done want lanes 17 and 1 done", od.size(), done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_elem();
    test_acc();
    test_lanes();
    test_back_to_back();
    test_backpressure();
    test_stagger();
    test_overflow();
    test_err();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
